imem_loader: RTL and testbench

// Write-side companion to the asynchronous-read instruction ROM: streams program bytes into a writable

---
 rtl/imem_loader.sv | 128 ++++++++++++
 tb/tb_imem_loader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream loader for the writable instruction memory: packs bytes little-endian into
// DATA_WIDTH words and issues one registered write per word at consecutive addresses.
module imem_loader #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   length,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     we,
  output logic [ADDRESS_WIDTH-1:0] wa,
  output logic [DATA_WIDTH-1:0]    wd,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               checksum
);

  localparam int unsigned Bytes    = DATA_WIDTH / 8;
  localparam int unsigned LaneW    = (Bytes > 1) ? $clog2(Bytes) : 1;
  localparam logic [LaneW-1:0] LastLane = LaneW'(Bytes - 1);
  localparam logic [ADDRESS_WIDTH:0] OneWord = (ADDRESS_WIDTH + 1)'(1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]               state, state_next;
  logic [ADDRESS_WIDTH-1:0] addr, addr_next;
  logic [ADDRESS_WIDTH:0]   words_left, words_left_next;
  logic [LaneW-1:0]         lane, lane_next;
  logic [DATA_WIDTH-1:0]    word_buf, word_buf_next, word_full;
  logic [7:0]               checksum_next;
  logic                     we_next;
  logic [ADDRESS_WIDTH-1:0] wa_next;
  logic [DATA_WIDTH-1:0]    wd_next;

  assign in_ready = (state == StLoad);
  assign busy     = (state == StLoad) || (state == StFlush);
  assign done     = (state == StDone);

  // Partial word with the incoming byte merged into its lane; used both to keep
  // accumulating and, on the last lane, as the word to write.
  always_comb begin
    word_full = word_buf;
    word_full[8*lane +: 8] = in_data;
  end

  always_comb begin
    state_next      = state;
    addr_next       = addr;
    words_left_next = words_left;
    lane_next       = lane;
    word_buf_next   = word_buf;
    checksum_next   = checksum;
    we_next         = 1'b0;
    wa_next         = wa;
    wd_next         = wd;

    case (state)
      StIdle: begin
        if (start) begin
          addr_next       = base_addr;
          words_left_next = length;
          lane_next       = '0;
          word_buf_next   = '0;
          checksum_next   = '0;
          state_next      = (length == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        if (in_valid) begin
          checksum_next = checksum + in_data;
          word_buf_next = word_full;
          if (lane == LastLane) begin
            we_next         = 1'b1;
            wa_next         = addr;
            wd_next         = word_full;
            addr_next       = addr + 1'b1;
            words_left_next = words_left - 1'b1;
            lane_next       = '0;
            if (words_left == OneWord) begin
              state_next = StFlush;
            end
          end else begin
            lane_next = lane + 1'b1;
          end
        end
      end
      StFlush: begin
        state_next = StDone;
      end
      default: begin
        state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      addr       <= '0;
      words_left <= '0;
      lane       <= '0;
      word_buf   <= '0;
      checksum   <= '0;
      we         <= 1'b0;
      wa         <= '0;
      wd         <= '0;
    end else begin
      state      <= state_next;
      addr       <= addr_next;
      words_left <= words_left_next;
      lane       <= lane_next;
      word_buf   <= word_buf_next;
      checksum   <= checksum_next;
      we         <= we_next;
      wa         <= wa_next;
      wd         <= wd_next;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: an 8-bit-word and a 32-bit-word instance share one byte stream and
// are checked every cycle against a byte-counting reference model, plus literal scenarios.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base_a = '0;
  logic [7:0] base_b = '0;
  logic [8:0] len_a = '0;
  logic [8:0] len_b = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;

  logic        ready_a, we_a, busy_a, done_a;
  logic [7:0]  wa_a, wd_a, ck_a;
  logic        ready_b, we_b, busy_b, done_b;
  logic [7:0]  wa_b, ck_b;
  logic [31:0] wd_b;

  always #5 clk = ~clk;

  imem_loader #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_a), .length(len_a),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ready_a), .we(we_a), .wa(wa_a),
    .wd(wd_a), .busy(busy_a), .done(done_a), .checksum(ck_a)
  );

  imem_loader #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) dut_b (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_b), .length(len_b),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ready_b), .we(we_b), .wa(wa_b),
    .wd(wd_b), .busy(busy_b), .done(done_b), .checksum(ck_b)
  );

  // Reference model: counts accepted bytes against length*bytes-per-word; a word is written the
  // cycle after its last byte, done follows the final write (or the start itself when length=0).
  bit          m_act[2];
  int          m_cnt[2];
  int          m_total[2];
  int          m_base[2];
  bit          m_pend[2];
  logic [31:0] m_word[2];
  logic        e_we[2];
  logic [7:0]  e_wa[2];
  logic [31:0] e_wd[2];
  logic        e_done[2];
  logic [7:0]  e_ck[2];
  int          bpw;
  bit          idle, nd, nw;
  logic [7:0]  bsel;
  logic [8:0]  lsel;

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_act[k] = 1'b0; m_cnt[k] = 0; m_total[k] = 0; m_base[k] = 0; m_pend[k] = 1'b0;
        m_word[k] = '0; e_we[k] = 1'b0; e_wa[k] = '0; e_wd[k] = '0; e_done[k] = 1'b0;
        e_ck[k] = '0;
      end else begin
        bpw  = (k == 0) ? 1 : 4;
        bsel = (k == 0) ? base_a : base_b;
        lsel = (k == 0) ? len_a : len_b;
        idle = !m_act[k] && !e_we[k] && !e_done[k];
        nd = m_pend[k];
        m_pend[k] = 1'b0;
        nw = 1'b0;
        if (idle && start) begin
          m_base[k] = int'(bsel);
          m_total[k] = int'(lsel) * bpw;
          m_cnt[k] = 0;
          m_word[k] = '0;
          e_ck[k] = '0;
          if (lsel == 0) nd = 1'b1;
          else m_act[k] = 1'b1;
        end else if (m_act[k] && in_valid) begin
          m_word[k] = m_word[k] | (32'(in_data) << (8 * (m_cnt[k] % bpw)));
          e_ck[k] = e_ck[k] + in_data;
          m_cnt[k]++;
          if (m_cnt[k] % bpw == 0) begin
            nw = 1'b1;
            e_wa[k] = 8'(m_base[k] + m_cnt[k] / bpw - 1);
            e_wd[k] = m_word[k];
            m_word[k] = '0;
          end
          if (m_cnt[k] == m_total[k]) begin
            m_act[k] = 1'b0;
            m_pend[k] = 1'b1;
          end
        end
        e_we[k] = nw;
        e_done[k] = nd;
      end
    end
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc_a = 0, done_cyc_a = -1, last_we_cyc_a = -1;
  int n_done_a = 0, n_done_b = 0, n_ready_b = 0;
  logic [39:0] log_a[$];
  logic [39:0] log_b[$];

  task automatic chk(input string name, input int k, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut=%0d cycle=%0d got=%0h expected=%0h", name, k, cyc, got, exp);
    end
  endtask

  task automatic compare_all();
    chk("in_ready", 0, 64'(ready_a), 64'(m_act[0]));
    chk("we", 0, 64'(we_a), 64'(e_we[0]));
    chk("wa", 0, 64'(wa_a), 64'(e_wa[0]));
    chk("wd", 0, 64'(wd_a), 64'(e_wd[0]));
    chk("busy", 0, 64'(busy_a), 64'(m_act[0] | e_we[0]));
    chk("done", 0, 64'(done_a), 64'(e_done[0]));
    chk("checksum", 0, 64'(ck_a), 64'(e_ck[0]));
    chk("in_ready", 1, 64'(ready_b), 64'(m_act[1]));
    chk("we", 1, 64'(we_b), 64'(e_we[1]));
    chk("wa", 1, 64'(wa_b), 64'(e_wa[1]));
    chk("wd", 1, 64'(wd_b), 64'(e_wd[1]));
    chk("busy", 1, 64'(busy_b), 64'(m_act[1] | e_we[1]));
    chk("done", 1, 64'(done_b), 64'(e_done[1]));
    chk("checksum", 1, 64'(ck_b), 64'(e_ck[1]));
  endtask

  task automatic tick();
    bit acc_a;
    acc_a = in_valid && ready_a;
    @(posedge clk);
    #1;
    cyc++;
    if (acc_a) last_acc_a = cyc;
    compare_all();
    if (we_a) begin log_a.push_back({wa_a, 32'(wd_a)}); last_we_cyc_a = cyc; end
    if (we_b) log_b.push_back({wa_b, wd_b});
    if (done_a) begin n_done_a++; done_cyc_a = cyc; end
    if (done_b) n_done_b++;
    if (ready_b) n_ready_b++;
  endtask

  task automatic start_load(input logic [7:0] ba, input logic [8:0] la,
                            input logic [7:0] bb, input logic [8:0] lb);
    base_a = ba; len_a = la; base_b = bb; len_b = lb;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data = b;
    tick();
  endtask

  int a0, b0, da, db, rb;

  initial begin
    #1 rst = 1'b1;
    @(posedge clk); #1;
    compare_all();
    chk("reset_outputs", 1, 64'({ready_b, we_b, busy_b, done_b, wa_b, wd_b, ck_b}), 64'(0));
    rst = 1'b0;
    tick();

    // 8-bit words at 0x10 alongside a zero-length load on the 32-bit instance
    a0 = log_a.size(); b0 = log_b.size(); da = n_done_a; db = n_done_b; rb = n_ready_b;
    start_load(8'h10, 9'd3, 8'h00, 9'd0);
    send(8'h13); send(8'h05); send(8'hFF);
    in_valid = 1'b0;
    repeat (4) tick();
    chk("t1_nwrites", 0, 64'(log_a.size() - a0), 64'(3));
    if (log_a.size() - a0 == 3) begin
      chk("t1_w0", 0, 64'(log_a[a0]), 64'({8'h10, 32'h13}));
      chk("t1_w1", 0, 64'(log_a[a0 + 1]), 64'({8'h11, 32'h05}));
      chk("t1_w2", 0, 64'(log_a[a0 + 2]), 64'({8'h12, 32'hFF}));
    end
    chk("t1_checksum", 0, 64'(ck_a), 64'(8'h17));
    chk("t1_write_latency", 0, 64'(last_we_cyc_a), 64'(last_acc_a));
    chk("t1_done_latency", 0, 64'(done_cyc_a), 64'(last_acc_a + 1));
    chk("t1_done_count", 0, 64'(n_done_a - da), 64'(1));
    chk("t4_nwrites", 1, 64'(log_b.size() - b0), 64'(0));
    chk("t4_done_count", 1, 64'(n_done_b - db), 64'(1));
    chk("t4_ready_never", 1, 64'(n_ready_b - rb), 64'(0));
    chk("t4_checksum", 1, 64'(ck_b), 64'(0));

    // 32-bit packing and 8-bit address wrap from 0xFE on the same stream
    a0 = log_a.size(); b0 = log_b.size(); da = n_done_a; db = n_done_b;
    start_load(8'hFE, 9'd4, 8'h00, 9'd2);
    for (int i = 1; i <= 8; i++) send(8'(i));
    in_valid = 1'b0;
    repeat (4) tick();
    chk("t2_nwrites", 1, 64'(log_b.size() - b0), 64'(2));
    if (log_b.size() - b0 == 2) begin
      chk("t2_w0", 1, 64'(log_b[b0]), 64'({8'h00, 32'h04030201}));
      chk("t2_w1", 1, 64'(log_b[b0 + 1]), 64'({8'h01, 32'h08070605}));
    end
    chk("t2_checksum", 1, 64'(ck_b), 64'(8'h24));
    chk("t2_done_count", 1, 64'(n_done_b - db), 64'(1));
    chk("t3_nwrites", 0, 64'(log_a.size() - a0), 64'(4));
    if (log_a.size() - a0 == 4) begin
      chk("t3_w0", 0, 64'(log_a[a0]), 64'({8'hFE, 32'h01}));
      chk("t3_w1", 0, 64'(log_a[a0 + 1]), 64'({8'hFF, 32'h02}));
      chk("t3_w2", 0, 64'(log_a[a0 + 2]), 64'({8'h00, 32'h03}));
      chk("t3_w3", 0, 64'(log_a[a0 + 3]), 64'({8'h01, 32'h04}));
    end
    chk("t3_done_count", 0, 64'(n_done_a - da), 64'(1));
    chk("t3_checksum", 0, 64'(ck_a), 64'(8'h0A));

    // reset after 6 bytes of a 3-word load, then a clean reload from the same base
    b0 = log_b.size();
    start_load(8'h00, 9'd0, 8'h20, 9'd3);
    for (int i = 0; i < 6; i++) send(8'(8'h11 + i));
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_reset_outputs", 1, 64'({ready_b, we_b, busy_b, done_b, wa_b, wd_b, ck_b}), 64'(0));
    tick();
    rst = 1'b0;
    chk("t5_writes_before_reset", 1, 64'(log_b.size() - b0), 64'(1));
    if (log_b.size() - b0 == 1) chk("t5_w0", 1, 64'(log_b[b0]), 64'({8'h20, 32'h14131211}));
    start_load(8'h00, 9'd0, 8'h20, 9'd1);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    in_valid = 1'b0;
    repeat (4) tick();
    chk("t5_reload_nwrites", 1, 64'(log_b.size() - b0), 64'(2));
    if (log_b.size() - b0 == 2) chk("t5_reload_w", 1, 64'(log_b[b0 + 1]), 64'({8'h20, 32'hDDCCBBAA}));
    chk("t5_reload_checksum", 1, 64'(ck_b), 64'(8'h0E));

    // full-depth load: 256 words from 0x80 wrap back to 0x7F
    a0 = log_a.size();
    start_load(8'h80, 9'd256, 8'h00, 9'd0);
    for (int i = 0; i < 256; i++) send(8'($urandom));
    in_valid = 1'b0;
    repeat (4) tick();
    chk("full_nwrites", 0, 64'(log_a.size() - a0), 64'(256));
    if (log_a.size() - a0 == 256) chk("full_last_addr", 0, 64'(log_a[a0 + 255][39:32]), 64'(8'h7F));

    // random gaps, spurious starts, occasional resets; model checks every cycle
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      start    = ($urandom_range(0, 7) == 0);
      base_a   = 8'($urandom);
      base_b   = 8'($urandom);
      len_a    = ($urandom_range(0, 9) == 0) ? 9'd0 : 9'($urandom_range(1, 12));
      len_b    = ($urandom_range(0, 9) == 0) ? 9'd0 : 9'($urandom_range(1, 4));
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      tick();
    end
    start = 1'b0;
    in_valid = 1'b0;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
